// File: rtl/sync_ram_arbiter_if.sv
// Request/response and RAM-side bus of the two-requester synchronous RAM arbiter.
// slave = arbiter view, master = client/RAM environment view.
interface sync_ram_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  a_valid;
    logic                  a_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  a_ready;
    logic                  a_rvalid;
    logic [DATA_WIDTH-1:0] a_rdata;

    logic                  b_valid;
    logic                  b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  b_ready;
    logic                  b_rvalid;
    logic [DATA_WIDTH-1:0] b_rdata;

    logic                  ram_we;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport slave (
        input  a_valid, a_we, a_addr, a_wdata,
        output a_ready, a_rvalid, a_rdata,
        input  b_valid, b_we, b_addr, b_wdata,
        output b_ready, b_rvalid, b_rdata,
        output ram_we, ram_re, ram_addr, ram_din,
        input  ram_dout
    );

    modport master (
        output a_valid, a_we, a_addr, a_wdata,
        input  a_ready, a_rvalid, a_rdata,
        output b_valid, b_we, b_addr, b_wdata,
        input  b_ready, b_rvalid, b_rdata,
        input  ram_we, ram_re, ram_addr, ram_din,
        output ram_dout
    );
endinterface

// File: rtl/sync_ram_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between requesters A and B,
// with zero-fill after reset. Optional grant counters: define SYNC_RAM_ARB_STATS_EN.
module sync_ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    sync_ram_arbiter_if.slave   bus,
    output logic                init_done
`ifdef SYNC_RAM_ARB_STATS_EN
    ,
    output logic [15:0]         a_grant_cnt,
    output logic [15:0]         b_grant_cnt
`endif
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] init_addr;
    logic                  rr_b;
    logic                  gnt_a, gnt_b;
    logic                  ram_we, ram_re;
    logic [ADDR_WIDTH-1:0] ram_addr, addr_hold;
    logic [DATA_WIDTH-1:0] ram_din, din_hold;
    logic                  pend_vld_p1, pend_id_p1;
    logic                  a_rvalid, b_rvalid;
    logic [DATA_WIDTH-1:0] a_rdata_hold, b_rdata_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == INIT && init_addr == LAST_ADDR) state_nxt = RUN;
    end

    // Arbitration and RAM drive; the RAM bus holds its last value on idle cycles.
    always_comb begin
        gnt_a    = 1'b0;
        gnt_b    = 1'b0;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = addr_hold;
        ram_din  = din_hold;
        if (state == INIT) begin
            ram_we   = 1'b1;
            ram_addr = init_addr;
            ram_din  = '0;
        end else begin
            gnt_a = bus.a_valid & (~bus.b_valid | ~rr_b);
            gnt_b = bus.b_valid & (~bus.a_valid |  rr_b);
            if (gnt_a) begin
                ram_we   = bus.a_we;
                ram_re   = ~bus.a_we;
                ram_addr = bus.a_addr;
                ram_din  = bus.a_wdata;
            end else if (gnt_b) begin
                ram_we   = bus.b_we;
                ram_re   = ~bus.b_we;
                ram_addr = bus.b_addr;
                ram_din  = bus.b_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_addr   <= '0;
            rr_b        <= 1'b0;
            pend_vld_p1 <= 1'b0;
            pend_id_p1  <= 1'b0;
        end else begin
            if (state == INIT) init_addr <= init_addr + ADDR_ONE;
            if (gnt_a)      rr_b <= 1'b1;
            else if (gnt_b) rr_b <= 1'b0;
            pend_vld_p1 <= (gnt_a & ~bus.a_we) | (gnt_b & ~bus.b_we);
            pend_id_p1  <= gnt_b;
        end
    end

    always_ff @(posedge clk) begin
        addr_hold <= ram_addr;
        din_hold  <= ram_din;
    end

    // ---- stage p1: read return, routed by the pending requester id ----
    assign a_rvalid = pend_vld_p1 & ~pend_id_p1;
    assign b_rvalid = pend_vld_p1 &  pend_id_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata_hold <= '0;
            b_rdata_hold <= '0;
        end else begin
            if (a_rvalid) a_rdata_hold <= bus.ram_dout;
            if (b_rvalid) b_rdata_hold <= bus.ram_dout;
        end
    end

    assign bus.a_ready  = gnt_a;
    assign bus.b_ready  = gnt_b;
    assign bus.a_rvalid = a_rvalid;
    assign bus.b_rvalid = b_rvalid;
    assign bus.a_rdata  = a_rvalid ? bus.ram_dout : a_rdata_hold;
    assign bus.b_rdata  = b_rvalid ? bus.ram_dout : b_rdata_hold;
    assign bus.ram_we   = ram_we;
    assign bus.ram_re   = ram_re;
    assign bus.ram_addr = ram_addr;
    assign bus.ram_din  = ram_din;
    assign init_done    = (state == RUN);

`ifdef SYNC_RAM_ARB_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_grant_cnt <= '0;
            b_grant_cnt <= '0;
        end else begin
            if (gnt_a) a_grant_cnt <= sat_inc16(a_grant_cnt);
            if (gnt_b) b_grant_cnt <= sat_inc16(b_grant_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_sync_ram_arbiter.sv
// Directed self-checking bench for sync_ram_arbiter with a behavioural synchronous RAM.
// Grant counters are checked when SYNC_RAM_ARB_STATS_EN is defined.
module tb_sync_ram_arbiter;

    logic clk;
    logic rst_n;
    logic init_done;
    int   checks;
    int   failures;

    sync_ram_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

`ifdef SYNC_RAM_ARB_STATS_EN
    logic [15:0] a_grant_cnt, b_grant_cnt;
`endif

    sync_ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .init_done (init_done)
`ifdef SYNC_RAM_ARB_STATS_EN
        ,
        .a_grant_cnt (a_grant_cnt),
        .b_grant_cnt (b_grant_cnt)
`endif
    );

    logic [7:0] mem [16];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        if (bus.ram_re) bus.ram_dout <= mem[bus.ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic we, input logic [3:0] addr, input logic [7:0] d);
        bus.a_valid = v; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = d;
    endtask

    task automatic drive_b(input logic v, input logic we, input logic [3:0] addr, input logic [7:0] d);
        bus.b_valid = v; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = d;
    endtask

    task automatic init_pass();
        for (int i = 0; i < 16; i++) begin
            chk("init_we",    32'(bus.ram_we),   32'd1);
            chk("init_re",    32'(bus.ram_re),   32'd0);
            chk("init_addr",  32'(bus.ram_addr), 32'(i));
            chk("init_din",   32'(bus.ram_din),  32'h00);
            chk("init_rdy",   32'({bus.a_ready, bus.b_ready}), 32'd0);
            chk("init_done0", 32'(init_done),    32'd0);
            step();
        end
        chk("init_done1", 32'(init_done), 32'd1);
    endtask

    initial begin
        checks = 0; failures = 0;
        clk = 1'b0; rst_n = 1'b0;
        bus.ram_dout = 8'h00;
        for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
        drive_a(1'b0, 1'b0, 4'd0, 8'h00);
        drive_b(1'b0, 1'b0, 4'd0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done",   32'(init_done),    32'd0);
        chk("rst_rvalid", 32'({bus.a_rvalid, bus.b_rvalid}), 32'd0);
        chk("rst_rdata",  32'({bus.a_rdata, bus.b_rdata}),   32'd0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        init_pass();

        // A writes AA to addr 1, then reads it back
        drive_a(1'b1, 1'b1, 4'd1, 8'hAA); #1;
        chk("wr_a_rdy",  32'(bus.a_ready),  32'd1);
        chk("wr_ram_we", 32'(bus.ram_we),   32'd1);
        chk("wr_din",    32'(bus.ram_din),  32'hAA);
        step();
        drive_a(1'b1, 1'b0, 4'd1, 8'h00); #1;
        chk("rd_a_rdy",  32'(bus.a_ready),  32'd1);
        chk("rd_ram_re", 32'(bus.ram_re),   32'd1);
        chk("wr_no_rv",  32'(bus.a_rvalid), 32'd0);
        step();
        drive_a(1'b0, 1'b0, 4'd0, 8'h00); #1;
        chk("rd_a_rv",   32'(bus.a_rvalid), 32'd1);
        chk("rd_a_data", 32'(bus.a_rdata),  32'hAA);
        chk("rd_b_rv",   32'(bus.b_rvalid), 32'd0);
        chk("idle_we_re", 32'({bus.ram_we, bus.ram_re}), 32'd0);
        chk("idle_addr_hold", 32'(bus.ram_addr), 32'd1);
        step();
        chk("rv_pulse",   32'(bus.a_rvalid), 32'd0);
        chk("rdata_hold", 32'(bus.a_rdata),  32'hAA);

        // B alone writes 55 to addr 2 (pointer returns to A)
        drive_b(1'b1, 1'b1, 4'd2, 8'h55); #1;
        chk("b_only_rdy", 32'(bus.b_ready), 32'd1);
        step();

        // both valid: A, B, A, B, A
        drive_a(1'b1, 1'b1, 4'd3, 8'h33);
        drive_b(1'b1, 1'b0, 4'd7, 8'h00); #1;
        chk("c1_rdy",  32'({bus.a_ready, bus.b_ready}), 32'b10);
        chk("c1_addr", 32'(bus.ram_addr), 32'd3);
        step();
        drive_a(1'b1, 1'b0, 4'd2, 8'h00); #1;
        chk("c2_rdy",  32'({bus.a_ready, bus.b_ready}), 32'b01);
        chk("c2_addr", 32'(bus.ram_addr), 32'd7);
        step();
        drive_b(1'b1, 1'b1, 4'd4, 8'h44); #1;
        chk("c3_rdy",  32'({bus.a_ready, bus.b_ready}), 32'b10);
        chk("c3_rv",   32'({bus.a_rvalid, bus.b_rvalid}), 32'b01);
        chk("c3_b_rd7", 32'(bus.b_rdata), 32'h00);
        step();
        drive_a(1'b1, 1'b0, 4'd3, 8'h00); #1;
        chk("c4_rdy",  32'({bus.a_ready, bus.b_ready}), 32'b01);
        chk("c4_rv",   32'({bus.a_rvalid, bus.b_rvalid}), 32'b10);
        chk("c4_a_rd2", 32'(bus.a_rdata), 32'h55);
        step();
        drive_b(1'b0, 1'b0, 4'd0, 8'h00); #1;
        chk("c5_rdy",  32'({bus.a_ready, bus.b_ready}), 32'b10);
        chk("c5_rv",   32'({bus.a_rvalid, bus.b_rvalid}), 32'b00);
        step();
        drive_a(1'b0, 1'b0, 4'd0, 8'h00); #1;
        chk("c6_rv",   32'({bus.a_rvalid, bus.b_rvalid}), 32'b10);
        chk("c6_a_rd3", 32'(bus.a_rdata), 32'h33);
        step();

        // B read accepted, then reset in the following cycle
        drive_b(1'b1, 1'b0, 4'd4, 8'h00); #1;
        chk("mr_b_rdy", 32'(bus.b_ready), 32'd1);
        step();
        rst_n = 1'b0;
        drive_b(1'b0, 1'b0, 4'd0, 8'h00);
        drive_a(1'b1, 1'b0, 4'd1, 8'h00); #1;
        chk("mr_no_rv",  32'(bus.b_rvalid), 32'd0);
        chk("mr_rdata",  32'(bus.b_rdata),  32'h00);
        chk("mr_done",   32'(init_done),    32'd0);
        chk("mr_addr0",  32'(bus.ram_addr), 32'd0);
        step();
        chk("mr_no_rv2", 32'(bus.b_rvalid), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        init_pass();

        // A reads addr 1 after the second zero-fill
        #1;
        chk("post_a_rdy", 32'(bus.a_ready), 32'd1);
        step();
        drive_b(1'b1, 1'b0, 4'd7, 8'h00);
        drive_a(1'b0, 1'b0, 4'd0, 8'h00); #1;
        chk("post_rv",   32'(bus.a_rvalid), 32'd1);
        chk("post_zero", 32'(bus.a_rdata),  32'h00);
        step();
        drive_b(1'b0, 1'b0, 4'd0, 8'h00);
        drive_a(1'b1, 1'b1, 4'd5, 8'h5A); #1;
        chk("post_b_rv7", 32'(bus.b_rvalid), 32'd1);
        step();
        drive_a(1'b0, 1'b0, 4'd0, 8'h00);
        drive_b(1'b1, 1'b1, 4'd6, 8'h66); #1;
        step();
        drive_b(1'b0, 1'b0, 4'd0, 8'h00);
        drive_a(1'b1, 1'b0, 4'd5, 8'h00); #1;
        step();
        drive_a(1'b0, 1'b0, 4'd0, 8'h00); #1;
        chk("post_a_rd5", 32'(bus.a_rdata),  32'h5A);
        chk("post_a_rv5", 32'(bus.a_rvalid), 32'd1);
`ifdef SYNC_RAM_ARB_STATS_EN
        chk("a_grant_cnt", 32'(a_grant_cnt), 32'd3);
        chk("b_grant_cnt", 32'(b_grant_cnt), 32'd2);
`endif
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
